id_handler: RTL and testbench

Player-ID front end of the login chain. Collects a 4-digit hex ID from the switches, one digit per button press, and scans an internal player table for a match. On a match it presents `MatchedID`, the player address and the guest flag to the password handler, and holds them until that handler returns a logout pulse. It is the ID-side initiator of the MatchedID / Logout handshake that the password handler responds to.

---
 rtl/id_handler_if.sv | 48 ++++
 rtl/id_handler.sv | 162 ++++++++++++++++
 tb/tb_id_handler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_handler_if.sv
// ----------------------------------------------------------------------------
// id_handler_if
// Bundles the switch/button inputs, the MatchedID / Logout handshake with the
// password handler and the status outputs of the player-ID front end.
//   master : the id_handler side (initiator of the MatchedID handshake)
//   slave  : the environment side (switches, debouncer, password handler)
// Signals:
//   Switches[3:0]            hex digit being entered
//   IDButton                 debounced button level, one digit per rising edge
//   Logout_from_PW           single-cycle logout pulse from the password handler
//   MatchedID                high while a matched player is held
//   PlayerAddress_to_PW[4:0] table address of the matched entry
//   isGuest_to_PW            matched entry is the guest account
//   IDError                  one-cycle pulse when no entry matches
//   DigitCount[2:0]          digits entered so far (0..4)
// ----------------------------------------------------------------------------
interface id_handler_if;
    logic [3:0] Switches;
    logic       IDButton;
    logic       Logout_from_PW;
    logic       MatchedID;
    logic [4:0] PlayerAddress_to_PW;
    logic       isGuest_to_PW;
    logic       IDError;
    logic [2:0] DigitCount;

    modport master (
        input  Switches,
        input  IDButton,
        input  Logout_from_PW,
        output MatchedID,
        output PlayerAddress_to_PW,
        output isGuest_to_PW,
        output IDError,
        output DigitCount
    );

    modport slave (
        output Switches,
        output IDButton,
        output Logout_from_PW,
        input  MatchedID,
        input  PlayerAddress_to_PW,
        input  isGuest_to_PW,
        input  IDError,
        input  DigitCount
    );
endinterface

// File: rtl/id_handler.sv
// ----------------------------------------------------------------------------
// id_handler
// Player-ID front end of the login chain. Collects four hex digits from the
// switches (one per button rising edge, MSB first), scans a fixed player
// table one entry per cycle and either holds the matched address/guest flag
// until the password handler pulses logout, or pulses IDError on a miss.
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   bus   id_handler_if.master (switches, button, logout, status outputs)
// Parameters:
//   NUM_ENTRIES  table entries scanned (1..32)
//   GUEST_ADDR   table address of the guest account
// All outputs are registered.
// ----------------------------------------------------------------------------
module id_handler #(
    parameter int NUM_ENTRIES = 8,
    parameter int GUEST_ADDR  = 4
) (
    input  logic          clk,
    input  logic          rst,
    id_handler_if.master  bus
);

    typedef enum logic [1:0] {
        ST_ENTER   = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_MATCHED = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

    localparam logic [4:0] LAST_IDX  = 5'(NUM_ENTRIES - 1);
    localparam logic [4:0] GUEST_IDX = 5'(GUEST_ADDR);

    state_e      state_q, state_d;
    logic        btn_q;
    logic [15:0] id_q, id_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  scan_q, scan_d;
    logic        matched_q, matched_d;
    logic [4:0]  addr_q, addr_d;
    logic        guest_q, guest_d;
    logic        err_q, err_d;

    logic        press;
    logic        hit;

    // Fixed player table; unpopulated addresses read zero.
    function automatic logic [15:0] table_rd(input logic [4:0] a);
        logic [15:0] v;
        case (a)
            5'd0:    v = 16'h0101;
            5'd1:    v = 16'h1234;
            5'd2:    v = 16'hBEEF;
            5'd3:    v = 16'hCAFE;
            5'd4:    v = 16'hFFFF;
            5'd5:    v = 16'h0F0F;
            5'd6:    v = 16'hA5A5;
            5'd7:    v = 16'h7777;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    assign press = bus.IDButton & ~btn_q;

    // Addresses 8 and up read zero but must never match, even an entered 0000.
    assign hit = (scan_q < 5'd8) && (id_q == table_rd(scan_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ENTER;
            btn_q     <= 1'b0;
            id_q      <= '0;
            cnt_q     <= '0;
            scan_q    <= '0;
            matched_q <= 1'b0;
            addr_q    <= '0;
            guest_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= bus.IDButton;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            matched_q <= matched_d;
            addr_q    <= addr_d;
            guest_q   <= guest_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        scan_d    = scan_q;
        matched_d = matched_q;
        addr_d    = addr_q;
        guest_d   = guest_q;
        err_d     = 1'b0;

        case (state_q)
            ST_ENTER: begin
                if (press) begin
                    id_d  = {id_q[11:0], bus.Switches};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d = ST_LOOKUP;
                        scan_d  = '0;
                    end
                end
            end

            ST_LOOKUP: begin
                if (hit) begin
                    state_d   = ST_MATCHED;
                    matched_d = 1'b1;
                    addr_d    = scan_q;
                    guest_d   = (scan_q == GUEST_IDX);
                end else if (scan_q == LAST_IDX) begin
                    // Error pulse and digit clear are registered on the way
                    // into FAIL so IDError is high exactly while in FAIL.
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    id_d    = '0;
                    cnt_d   = '0;
                end else begin
                    scan_d = scan_q + 5'd1;
                end
            end

            ST_MATCHED: begin
                if (bus.Logout_from_PW) begin
                    state_d   = ST_ENTER;
                    matched_d = 1'b0;
                    addr_d    = '0;
                    guest_d   = 1'b0;
                    id_d      = '0;
                    cnt_d     = '0;
                    scan_d    = '0;
                end
            end

            ST_FAIL: begin
                state_d = ST_ENTER;
                id_d    = '0;
                cnt_d   = '0;
            end

            default: state_d = ST_ENTER;
        endcase
    end

    assign bus.MatchedID           = matched_q;
    assign bus.PlayerAddress_to_PW = addr_q;
    assign bus.isGuest_to_PW       = guest_q;
    assign bus.IDError             = err_q;
    assign bus.DigitCount          = cnt_q;

endmodule

// File: tb/tb_id_handler.sv
// ----------------------------------------------------------------------------
// tb_id_handler
// Directed walk through reset, match, guest, miss, held-button, logout and
// reset-during-scan cases, followed by randomized IDs. Expected results come
// from a lookup over the player table and the stated latencies.
// ----------------------------------------------------------------------------
module tb_id_handler;

    localparam int NUM_ENTRIES = 8;
    localparam int GUEST_ADDR  = 4;

    localparam logic [15:0] REF_TAB [8] = '{
        16'h0101, 16'h1234, 16'hBEEF, 16'hCAFE,
        16'hFFFF, 16'h0F0F, 16'hA5A5, 16'h7777
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    id_handler_if bus ();

    id_handler #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .GUEST_ADDR  (GUEST_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First table address (within the scanned range) holding id, else -1.
    function automatic int ref_lookup(input logic [15:0] id);
        for (int a = 0; a < NUM_ENTRIES && a < 8; a++)
            if (REF_TAB[a] == id) return a;
        return -1;
    endfunction

    // One button press; after the last digit we stop right after its edge.
    task automatic press(input logic [3:0] d, input bit is_last);
        bus.Switches = d;
        bus.IDButton = 1'b1;
        tick();
        bus.IDButton = 1'b0;
        if (!is_last) tick();
    endtask

    task automatic enter_id(input logic [15:0] id);
        for (int i = 0; i < 4; i++)
            press(id[15 - 4*i -: 4], (i == 3));
    endtask

    // Called just after the edge that captured the 4th digit.
    task automatic wait_result(input logic [15:0] id);
        int exp_k;
        int lat_m;
        int lat_e;
        exp_k = ref_lookup(id);
        lat_m = 0;
        lat_e = 0;
        chk("digits_full", {29'd0, bus.DigitCount}, 32'd4);
        for (int i = 1; i <= NUM_ENTRIES + 2; i++) begin
            tick();
            if (bus.MatchedID && lat_m == 0) lat_m = i;
            if (bus.IDError && lat_e == 0) lat_e = i;
            if (lat_m != 0 || lat_e != 0) break;
        end
        if (exp_k >= 0) begin
            chk("match_latency", lat_m, exp_k + 1);
            chk("match_no_err", lat_e, 0);
            chk("match_addr", {27'd0, bus.PlayerAddress_to_PW}, exp_k);
            chk("match_guest", {31'd0, bus.isGuest_to_PW}, (exp_k == GUEST_ADDR) ? 1 : 0);
            $display("[TB] id %04h -> match addr %0d after %0d cycles", id, lat_m - 1, lat_m);
        end else begin
            chk("miss_latency", lat_e, NUM_ENTRIES);
            chk("miss_no_match", {31'd0, bus.MatchedID}, 32'd0);
            chk("miss_cnt_clear", {29'd0, bus.DigitCount}, 32'd0);
            tick();
            chk("miss_err_one_cycle", {31'd0, bus.IDError}, 32'd0);
            $display("[TB] id %04h -> miss, IDError after %0d cycles", id, lat_e);
        end
    endtask

    task automatic logout();
        bus.Logout_from_PW = 1'b1;
        tick();
        bus.Logout_from_PW = 1'b0;
        chk("logout_matched", {31'd0, bus.MatchedID}, 32'd0);
        chk("logout_addr", {27'd0, bus.PlayerAddress_to_PW}, 32'd0);
        chk("logout_guest", {31'd0, bus.isGuest_to_PW}, 32'd0);
        chk("logout_cnt", {29'd0, bus.DigitCount}, 32'd0);
        $display("[TB] logout");
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] packed_out;
        packed_out = {20'd0, bus.MatchedID, bus.PlayerAddress_to_PW,
                      bus.isGuest_to_PW, bus.IDError, bus.DigitCount};
        chk(tag, packed_out, 32'd0);
    endtask

    initial begin
        logic [15:0] id;
        bit          rose;
        bus.Switches       = 4'h0;
        bus.IDButton       = 1'b0;
        bus.Logout_from_PW = 1'b0;
        rst = 1'b0;
        tick();
        chk_all_zero("reset_state");
        tick();
        rst = 1'b1;
        tick();
        $display("[TB] reset released");

        // Reset mid-entry, then 1234 -> address 1.
        press(4'h1, 0);
        press(4'h2, 0);
        chk("two_digits", {29'd0, bus.DigitCount}, 32'd2);
        #2 rst = 1'b0;
        #1 chk_all_zero("reset_mid_entry");
        rst = 1'b1;
        tick();
        enter_id(16'h1234);
        wait_result(16'h1234);
        logout();

        // Guest account.
        enter_id(16'hFFFF);
        wait_result(16'hFFFF);
        logout();

        // Miss, then CAFE.
        enter_id(16'h0034);
        wait_result(16'h0034);
        enter_id(16'hCAFE);
        wait_result(16'hCAFE);

        // Presses while matched must not disturb the held result.
        press(4'h1, 0);
        press(4'h9, 0);
        press(4'hE, 0);
        chk("matched_hold", {31'd0, bus.MatchedID}, 32'd1);
        chk("matched_addr_hold", {27'd0, bus.PlayerAddress_to_PW}, 32'd3);
        chk("matched_guest_hold", {31'd0, bus.isGuest_to_PW}, 32'd0);

        // Logout with the button rising in the same cycle; held across ENTER.
        bus.IDButton = 1'b1;
        logout();
        tick();
        tick();
        chk("held_across_logout", {29'd0, bus.DigitCount}, 32'd0);
        bus.IDButton = 1'b0;
        tick();

        // Held button enters exactly one digit.
        bus.Switches = 4'h7;
        bus.IDButton = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("held_one_digit", {29'd0, bus.DigitCount}, 32'd1);
        bus.IDButton = 1'b0;
        tick();
        press(4'h7, 0);
        press(4'h7, 0);
        press(4'h7, 1);
        wait_result(16'h7777);
        logout();

        // Logout while in ENTER is ignored.
        press(4'hA, 0);
        press(4'h5, 0);
        bus.Logout_from_PW = 1'b1;
        tick();
        bus.Logout_from_PW = 1'b0;
        chk("logout_in_enter", {29'd0, bus.DigitCount}, 32'd2);
        press(4'hA, 0);
        press(4'h5, 1);
        wait_result(16'hA5A5);
        logout();

        // Reset during the scan of BEEF: the match must never appear.
        enter_id(16'hBEEF);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset_in_lookup");
        rst = 1'b1;
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.MatchedID) rose = 1;
        end
        chk("no_match_after_reset", {31'd0, rose}, 32'd0);
        enter_id(16'h1234);
        wait_result(16'h1234);
        logout();

        // Randomized IDs, half drawn from the table.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                id = REF_TAB[$urandom_range(0, 7)];
            else
                id = 16'($urandom);
            enter_id(id);
            wait_result(id);
            if (bus.MatchedID) begin
                if ($urandom_range(0, 1) == 1) press(4'($urandom), 0);
                chk("rand_hold", {27'd0, bus.PlayerAddress_to_PW}, ref_lookup(id));
                logout();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
